// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the 6502C T-state sequencer.
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_INTSEQ = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        KIND_RST = 2'd0,
        KIND_NMI = 2'd1,
        KIND_IRQ = 2'd2,
        KIND_BRK = 2'd3
    } int_kind_e;

    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_RST = 8'hFC;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    localparam int INTSEQ_LAST   = 7;
    // An NMI pending by the end of T4 can still redirect the vector fetch.
    localparam int HIJACK_LAST_T = 4;
    localparam int NMI_CLR_T     = 5;

    function automatic logic [3:0] clamp_len(input logic [3:0] cyc, input logic [3:0] t_max);
        if (cyc < 4'd2 || cyc > t_max) begin
            return t_max;
        end
        return cyc;
    endfunction

endpackage

// File: rtl/irq_priority_arb.sv
// Maskable IRQ arbitration: enable/I-flag gating and lowest-index priority pick.
module irq_priority_arb #(
    parameter int NUM_IRQ = 4,
    localparam int S_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] irq_n_i,
    input  logic [NUM_IRQ-1:0] irq_mask_i,
    input  logic               i_flag_i,
    output logic               irq_any_o,
    output logic [S_W-1:0]     irq_idx_o
);

    logic [NUM_IRQ-1:0] active;

    assign active    = ~irq_n_i & irq_mask_i;
    assign irq_any_o = (|active) & ~i_flag_i;

    // Descending scan so the lowest active index is the last one written.
    always_comb begin
        irq_idx_o = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                irq_idx_o = S_W'(i);
            end
        end
    end

endmodule

// File: rtl/tstate_sequencer.sv
// T-state sequencer and interrupt controller feeding the 6502C control PLA.
//   state     | meaning
//   ST_FETCH  | T1 opcode fetch, sync high, predecode sampled at its end
//   ST_EXEC   | T2..len of a normal instruction (branches may extend len)
//   ST_INTSEQ | T2..T7 of a RST/NMI/IRQ/BRK sequence
module tstate_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int T_MAX   = 7,
    parameter int NUM_IRQ = 4,
    localparam int T_W = $clog2(T_MAX + 1),
    localparam int S_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               phi1,
    input  logic               rst_n,
    input  logic               rdy,
    input  logic               rw_read,
    input  logic [3:0]         cyc_count,
    input  logic               is_brk,
    input  logic               is_branch,
    input  logic               branch_taken,
    input  logic               page_cross,
    input  logic               nmi_n,
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               i_flag,
    output logic [T_W-1:0]     t_state,
    output logic               sync,
    output logic               int_active,
    output logic [1:0]         int_kind,
    output logic [7:0]         vec_lo,
    output logic [S_W-1:0]     irq_src,
    output logic               force_brk,
    output logic               wr_inhibit,
    output logic               set_b
);

    localparam logic [T_W-1:0] T_ONE      = T_W'(1);
    localparam logic [T_W-1:0] T_TWO      = T_W'(2);
    localparam logic [T_W-1:0] T_THREE    = T_W'(3);
    localparam logic [T_W-1:0] T_TOP      = T_W'(T_MAX);
    localparam logic [T_W-1:0] T_INT_LAST = T_W'(INTSEQ_LAST);
    localparam logic [T_W-1:0] T_HIJACK   = T_W'(HIJACK_LAST_T);
    localparam logic [T_W-1:0] T_NMI_CLR  = T_W'(NMI_CLR_T);

    seq_state_e     state_q;
    int_kind_e      int_kind_q;
    logic [T_W-1:0] t_q;
    logic [T_W-1:0] len_q;
    logic [T_W-1:0] len_d;
    logic           branch_q;
    logic           sync_q;
    logic           int_active_q;
    logic [7:0]     vec_lo_q;
    logic [S_W-1:0] irq_src_q;
    logic           force_brk_q;
    logic           wr_inhibit_q;
    logic           set_b_q;
    logic           nmi_prev_q;
    logic           nmi_pend_q;
    logic           nmi_pend_d;

    logic           stall;
    logic           nmi_fall;
    logic           nmi_clear;
    logic           extend;
    logic           last_exec;
    logic           hijack;
    logic           irq_any;
    logic [S_W-1:0] irq_idx;

    irq_priority_arb #(
        .NUM_IRQ(NUM_IRQ)
    ) u_arb (
        .irq_n_i   (irq_n),
        .irq_mask_i(irq_mask),
        .i_flag_i  (i_flag),
        .irq_any_o (irq_any),
        .irq_idx_o (irq_idx)
    );

    assign stall     = ~rdy & rw_read;
    assign nmi_fall  = nmi_prev_q & ~nmi_n;
    assign nmi_clear = !stall && state_q == ST_INTSEQ && t_q == T_NMI_CLR
                       && int_kind_q == KIND_NMI;
    // A fresh falling edge wins over the T6 clear so it is never lost.
    assign nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clear);

    assign len_d  = is_branch ? T_TWO : T_W'(clamp_len(cyc_count, 4'(T_MAX)));
    assign extend = branch_q && ((t_q == T_TWO && branch_taken)
                                 || (t_q == T_THREE && page_cross));
    assign last_exec = (t_q >= len_q || t_q >= T_TOP) && !extend;
    assign hijack = nmi_pend_q && t_q <= T_HIJACK
                    && (int_kind_q == KIND_IRQ || int_kind_q == KIND_BRK);

    always_ff @(posedge phi1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            t_q          <= T_ONE;
            len_q        <= T_TWO;
            branch_q     <= 1'b0;
            sync_q       <= 1'b0;
            int_active_q <= 1'b1;
            int_kind_q   <= KIND_RST;
            vec_lo_q     <= VEC_RST;
            irq_src_q    <= '0;
            force_brk_q  <= 1'b1;
            wr_inhibit_q <= 1'b1;
            set_b_q      <= 1'b0;
            nmi_prev_q   <= 1'b1;
            nmi_pend_q   <= 1'b0;
        end else begin
            nmi_prev_q <= nmi_n;
            nmi_pend_q <= nmi_pend_d;
            if (!stall) begin
                case (state_q)
                    ST_FETCH: begin
                        sync_q <= 1'b0;
                        t_q    <= T_TWO;
                        if (force_brk_q || is_brk) begin
                            state_q      <= ST_INTSEQ;
                            int_active_q <= 1'b1;
                            if (!force_brk_q) begin
                                int_kind_q <= KIND_BRK;
                                vec_lo_q   <= VEC_IRQ;
                                set_b_q    <= 1'b1;
                            end
                        end else begin
                            state_q  <= ST_EXEC;
                            len_q    <= len_d;
                            branch_q <= is_branch;
                        end
                    end
                    ST_EXEC, ST_INTSEQ: begin
                        if ((state_q == ST_EXEC && last_exec)
                            || (state_q == ST_INTSEQ && t_q == T_INT_LAST)) begin
                            state_q      <= ST_FETCH;
                            t_q          <= T_ONE;
                            sync_q       <= 1'b1;
                            force_brk_q  <= 1'b0;
                            int_active_q <= 1'b0;
                            wr_inhibit_q <= 1'b0;
                            set_b_q      <= 1'b0;
                            if (nmi_pend_d) begin
                                force_brk_q  <= 1'b1;
                                int_active_q <= 1'b1;
                                int_kind_q   <= KIND_NMI;
                                vec_lo_q     <= VEC_NMI;
                            end else if (irq_any) begin
                                force_brk_q  <= 1'b1;
                                int_active_q <= 1'b1;
                                int_kind_q   <= KIND_IRQ;
                                vec_lo_q     <= VEC_IRQ;
                                irq_src_q    <= irq_idx;
                            end
                        end else begin
                            t_q <= t_q + T_ONE;
                            if (state_q == ST_EXEC && extend) begin
                                len_q <= len_q + T_ONE;
                            end
                            if (state_q == ST_INTSEQ && hijack) begin
                                int_kind_q <= KIND_NMI;
                                vec_lo_q   <= VEC_NMI;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_FETCH;
                        t_q     <= T_ONE;
                    end
                endcase
            end
        end
    end

    assign t_state    = t_q;
    assign sync       = sync_q;
    assign int_active = int_active_q;
    assign int_kind   = int_kind_q;
    assign vec_lo     = vec_lo_q;
    assign irq_src    = irq_src_q;
    assign force_brk  = force_brk_q;
    assign wr_inhibit = wr_inhibit_q;
    assign set_b      = set_b_q;

endmodule

// File: doc/tstate_sequencer.md
# tstate_sequencer

Parametrised T-state sequencer and interrupt controller for the 6502C core, sitting between the predecode logic and the control-signal PLA. It produces the per-cycle T count, SYNC, and interrupt-sequence qualifiers the PLA uses to select control words. It generalises the core FSM with a parameterised maximum instruction length, N maskable IRQ channels with fixed priority, branch-extension cycles, read-only RDY stalling and NMI hijack of IRQ/BRK sequences.

## Interface
- T_MAX, 7: longest instruction in cycles, 7..15; T_W = $clog2(T_MAX+1).
- NUM_IRQ, 4: maskable IRQ channels, 1..8; S_W = max(1,$clog2(NUM_IRQ)).
- phi1  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  stall request; honoured only on read cycles.
- rw_read  in  1  current bus cycle is a read.
- cyc_count  in  4  predecoded cycle count of fetched opcode, 2..T_MAX, sampled at end of FETCH.
- is_brk, is_branch  in  1  predecode qualifiers, sampled with cyc_count.
- branch_taken  in  1  valid at the end of T2 of a branch.
- page_cross  in  1  valid at the end of T3 of a taken branch.
- nmi_n  in  1  edge-triggered, falling edge requests NMI.
- irq_n  in  NUM_IRQ  level, active-low requests.
- irq_mask  in  NUM_IRQ  1 = channel enabled.
- i_flag  in  1  P register I bit.
- t_state  out  T_W  current T (1 = FETCH); reset 1.
- sync  out  1  high in FETCH; reset 0.
- int_active  out  1  interrupt/BRK/reset sequence in progress; reset 1.
- int_kind  out  2  0 RST, 1 NMI, 2 IRQ, 3 BRK; reset 0.
- vec_lo  out  8  vector low byte FC/FA/FE; reset 8'hFC.
- irq_src  out  S_W  winning IRQ channel; reset 0.
- force_brk  out  1  discard fetched opcode, inhibit PC increment; reset 1.
- wr_inhibit  out  1  suppress writes (reset sequence only); reset 1.
- set_b  out  1  push B=1 (BRK only); reset 0.

## Operation
- States: FETCH, EXEC, INTSEQ.
- Reset: asserting rst_n forces FETCH with reset output values; after release, an RST sequence runs: one FETCH (force_brk=1) then INTSEQ T2..T7, wr_inhibit=1 throughout.
- FETCH: sync=1. Next state:
  - INTSEQ if force_brk or is_brk.
  - Otherwise EXEC at T2, latching cyc_count into len.
- EXEC: t_state increments each cycle. The last cycle is t_state==len; the next state is FETCH.
- Branch: len=2 at fetch. If branch_taken at T2, len becomes 3. If also page_cross at T3, len becomes 4.
- INTSEQ: T2..T7 fixed (7 cycles including FETCH), then FETCH with force_brk=0 and int_active=0.
- Interrupt sampling: on the edge ending the last EXEC cycle or T7 of INTSEQ.
  - NMI pending has priority; IRQ pending = |(~irq_n & irq_mask) & ~i_flag.
  - If either is pending, the next FETCH has force_brk=1, int_active=1 and int_kind/vec_lo/irq_src set.
  - irq_src is the lowest-index active enabled channel.
- NMI edge: nmi_n is sampled every cycle, and 1→0 sets nmi_pend. nmi_pend clears on entry to INTSEQ T6 of an NMI-kind sequence, and is not cleared by IRQ.
- NMI hijack: an nmi_pend set before INTSEQ T5 of an IRQ/BRK sequence switches int_kind to NMI and vec_lo to FA. set_b stays as latched. nmi_pend clears at T6.
- A BRK opcode whose sequence has int_kind=3 has set_b=1. A forced IRQ/NMI has set_b=0.
- RDY stall: with rdy=0 and rw_read=1, all registers hold, including nmi_pend set, which is still allowed. With rw_read=0, rdy is ignored.

## Timing
- All outputs are registered; zero combinational input→output paths.
- cyc_count/is_brk/is_branch are sampled on the edge ending FETCH, so an EXEC T2 output is visible one cycle after sync.
- An interrupt asserted on the final instruction cycle is taken at the next FETCH. An interrupt asserted one cycle later waits for the following instruction.
- Reset mid-instruction aborts immediately: the asynchronous clear of all state, with no partial sequence.
- Simultaneous rdy stall and nmi_n fall: the edge is captured; T holds.
- t_state never exceeds T_MAX. A cyc_count outside 2..T_MAX is clamped to T_MAX.

## Structure
- Package cpu_seq_pkg: state enum, int_kind codes, vector constants FA/FC/FE, INTSEQ_LAST=7.
- Sub-module irq_priority_arb: mask and I-flag gating, lowest-index priority encoder, any-pending output; parameter NUM_IRQ.

## Test plan
- Release rst_n → 1 FETCH + T2..T7 with int_kind=0, vec_lo=FC, wr_inhibit=1, then sync=1 with force_brk=0.
- Fetch with cyc_count=4 → t_state 1,2,3,4,1. Hold rdy=0 on T3 read for 3 cycles → T3 held for 4 cycles total.
- Branch with taken=1 and page_cross=1 → t_state 1,2,3,4,1. With taken=0 → 1,2,1.
- irq_n=4'b0101, mask=4'b1110, i_flag=0 on last cycle → next FETCH force_brk=1, int_kind=2, irq_src=1, vec_lo=FE. With i_flag=1 → no interrupt.
- BRK, then nmi_n falls during INTSEQ T3 → int_kind=1, vec_lo=FA, set_b=1, nmi_pend cleared at T6. A second NMI is not taken without a new edge.
- rst_n low during EXEC T3 → immediate reset values, then the full RST sequence.
